// File: rtl/lidar_pc_pkg.sv
// Shared LiDAR point-cloud types and widths.
// Used by the point cloud assembler blocks.
package lidar_pc_pkg;

  localparam int unsigned POINT_W = 128;
  localparam int unsigned PPW     = 4;
  localparam int unsigned WORD_W  = POINT_W * PPW;
  localparam int unsigned CNT_W   = 16;

  localparam int unsigned FLAG_POINT_OK = 120;

  typedef struct packed {
    logic [7:0]  flags;
    logic [7:0]  ring;
    logic [15:0] intensity;
    logic [31:0] z;
    logic [31:0] y;
    logic [31:0] x;
  } point_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/point_word_accumulator.sv
// Packs kept points into PPW-point words, dropping
// points without point_ok; flushes on end of frame.
module point_word_accumulator #(
  parameter int unsigned POINT_W = 128,
  parameter int unsigned PPW     = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [POINT_W-1:0]     in_point,
  input  logic                   in_last,
  output logic [POINT_W*PPW-1:0] buffer_next,
  output logic                   write_full,
  output logic [PPW-1:0]         word_mask,
  output logic [2:0]             fill_count,
  output logic [CNT_W-1:0]       dropped_count,
  output logic [CNT_W-1:0]       word_count
);

  import lidar_pc_pkg::*;

  localparam logic [2:0] LAST_SLOT = 3'(PPW - 1);

  logic [PPW-2:0][POINT_W-1:0] part_q;
  logic [PPW-2:0][POINT_W-1:0] part_d;
  logic [2:0]                  cnt_q;
  logic [2:0]                  cnt_d;

  logic           valid_eff;
  logic           kept;
  logic           dropped;
  logic           wf;
  logic [PPW-1:0] mask_all;

  // Inputs are ignored while reset is held.
  assign valid_eff = in_valid & ~reset;
  assign kept      = valid_eff & in_point[FLAG_POINT_OK];
  assign dropped   = valid_eff & ~in_point[FLAG_POINT_OK];

  assign wf = valid_eff &
              ((kept & (cnt_q == LAST_SLOT)) |
               (in_last & (kept | (cnt_q != 3'd0))));

  always_comb begin
    buffer_next = '0;
    mask_all    = '0;
    for (int k = 0; k < int'(PPW); k++) begin
      if (cnt_q > 3'(k)) begin
        if (k < int'(PPW) - 1) begin
          buffer_next[k*POINT_W +: POINT_W] = part_q[k];
        end
        mask_all[k] = 1'b1;
      end else if ((cnt_q == 3'(k)) && kept) begin
        buffer_next[k*POINT_W +: POINT_W] = in_point;
        mask_all[k] = 1'b1;
      end
    end
  end

  always_comb begin
    part_d = part_q;
    cnt_d  = cnt_q;
    if (wf) begin
      part_d = '0;
      cnt_d  = 3'd0;
    end else if (kept) begin
      for (int k = 0; k < int'(PPW) - 1; k++) begin
        if (cnt_q == 3'(k)) begin
          part_d[k] = in_point;
        end
      end
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      part_q <= '0;
      cnt_q  <= 3'd0;
    end else begin
      part_q <= part_d;
      cnt_q  <= cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (dropped),
    .count (dropped_count)
  );

  sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wf),
    .count (word_count)
  );

  assign write_full = wf;
  assign word_mask  = wf ? mask_all : '0;
  assign fill_count = cnt_q;

endmodule
